systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
// PURPOSE
//  Responder to the array controller's read/write strobe bus. Captures the N*N PE accumulator
//  results into a shadow buffer when `read` strobes, then streams them out one word per beat on a
//  valid/ready port while the array is cleared and reloaded. Sits between the PE grid and the
//  result sink (memory writer / host FIFO).
// PARAMETERS
//  N   5   array dimension; N*N PEs, PE index i = row*N + col
//  DW  16  PE result width in bits
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  read       in   N*N      per-PE capture strobe from controller; bit i captures PE i
//  pe_data    in   N*N*DW   PE results; PE i at [i*DW +: DW]
//  out_data   out  DW       streamed result word
//  out_valid  out  1        out_data valid
//  out_ready  in   1        sink accepts beat when out_valid && out_ready
//  out_idx    out  log2(N*N) PE index of current beat (width clog2(N*N), min 1)
//  out_last   out  1        high on final beat of a frame
//  busy       out  1        high while in DRAIN
//  overrun    out  1        sticky: capture strobe arrived while busy
// BEHAVIOUR
//  - Reset (async assert, sync deassert to clk): state=IDLE, buffer=0, out_data=0, out_valid=0,
//    out_idx=0, out_last=0, busy=0, overrun=0.
//  - FSM states:
//    - IDLE -> DRAIN on any read bit set.
//    - DRAIN -> IDLE on handshake of the last beat.
//  - Capture (IDLE): every set read[i] loads buf[i] <= pe_data[i] at that edge. Unset bits keep
//    their old buf value.
//  - Latency: read sampled at edge t; out_valid=1, out_idx=0, out_data=buf[0] after edge t+1
//    (visible in cycle t+1).
//  - Drain order: buf[0]..buf[N*N-1]. out_data/out_idx/out_last are registered.
//  - Handshake: out_data/out_idx/out_last hold stable while out_valid && !out_ready. On a
//    handshake, advance one index per cycle. out_valid never drops mid-frame.
//  - out_last=1 exactly when out_idx==N*N-1 (or the final sum beat when the macro is set).
//  - Last handshake: out_valid=0 and busy=0 next cycle, unless a restart applies (below).
//  - read while DRAIN (not on last handshake cycle): capture ignored, buffer unchanged,
//    overrun<=1. overrun stays set until rst_n.
//  - read on the same cycle as the last handshake: treated as a new capture. Stay in DRAIN,
//    out_idx=0 next cycle with the new data, no gap beat, overrun not set.
//  - out_ready with out_valid=0: no effect. busy == out_valid at all times.
//  - Reset mid-frame: frame abandoned immediately, all outputs to reset values.
// CONFIGURATION
//  SYS_DRAIN_ROW_SUM_EN:
//   - Defined: after each row's N beats, one extra beat carries the row sum (mod 2^DW),
//     flagged by an extra output `out_is_sum` (1 bit).
//   - On a sum beat, out_idx holds the row's last PE index.
//   - Frame = N*N+N beats; out_last is on the final row-sum beat.
//  - Undefined: no out_is_sum port; frame = N*N beats.
// TESTING
//  1. Reset: rst_n=0 mid-clock -> all outputs 0 immediately, no clk edge needed.
//  2. Full drain, N=5: pe_data[i]=3*i, read=all-ones one cycle, out_ready=1 ->
//     25 beats, data 0,3,..,72, first valid 1 cycle after read, out_last only on beat 25,
//     busy falls the next cycle.
//  3. Backpressure: out_ready=0 for 3 cycles while out_idx=7 -> out_data=21 and out_idx=7
//     held stable, out_valid stays 1; then beats 8..24 resume with no loss or duplication.
//  4. Overrun: second read at out_idx=10 with pe_data changed to 1000+i -> stream stays
//     3*i, overrun=1 and sticky; a later read after IDLE streams 1000+i.
//  5. Back-to-back: read on the out_last handshake cycle -> next cycle out_idx=0 with new
//     data, busy stays 1, overrun=0.
//  6. SYS_DRAIN_ROW_SUM_EN, data as in test 2 ->
//     - 30 beats; beat 6 is a sum beat: out_is_sum=1, data=30;
//     - final beat data=330 with out_last=1.

Source files
------------

// File: rtl/systolic_result_drain_if.sv
// Strobe/result bus between the array controller, PE grid, result sink and systolic_result_drain.
// out_is_sum exists only when SYS_DRAIN_ROW_SUM_EN is defined.
interface systolic_result_drain_if #(
   parameter int unsigned N  = 5,
   parameter int unsigned DW = 16
);
   localparam int unsigned NN = N * N;
   localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;

   logic [NN-1:0]    read;
   logic [NN*DW-1:0] pe_data;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready;
   logic [IW-1:0]    out_idx;
   logic             out_last;
   logic             busy;
   logic             overrun;
`ifdef SYS_DRAIN_ROW_SUM_EN
   logic             out_is_sum;

   modport master (
      output read, pe_data, out_ready,
      input  out_data, out_valid, out_idx, out_last, busy, overrun, out_is_sum
   );
   modport slave (
      input  read, pe_data, out_ready,
      output out_data, out_valid, out_idx, out_last, busy, overrun, out_is_sum
   );
`else
   modport master (
      output read, pe_data, out_ready,
      input  out_data, out_valid, out_idx, out_last, busy, overrun
   );
   modport slave (
      input  read, pe_data, out_ready,
      output out_data, out_valid, out_idx, out_last, busy, overrun
   );
`endif
endinterface

// File: rtl/systolic_result_drain.sv
// Captures N*N PE results into a shadow buffer on a read strobe and streams them on valid/ready.
// Define SYS_DRAIN_ROW_SUM_EN to append a row-sum beat (flagged by out_is_sum) after each row.
module systolic_result_drain #(
   parameter int unsigned N  = 5,
   parameter int unsigned DW = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   systolic_result_drain_if.slave bus
);
   localparam int unsigned   NN      = N * N;
   localparam int unsigned   IW      = (NN > 1) ? $clog2(NN) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(NN - 1);

   typedef enum logic [0:0] {StIdle, StDrain} state_e;

   state_e        r_state, w_state_d;
   logic [DW-1:0] r_buf [NN];
   logic [DW-1:0] r_data, w_data_d;
   logic [IW-1:0] r_idx, w_idx_d, w_idx_inc;
   logic          r_last, w_last_d;
   logic          r_overrun, w_overrun_d;
   logic          w_capture, w_any_read, w_hs;
   logic [DW-1:0] w_word0, w_word_inc;

`ifdef SYS_DRAIN_ROW_SUM_EN
   localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LastCol = CW'(N - 1);

   logic          r_is_sum, w_is_sum_d;
   logic [DW-1:0] r_acc, w_acc_d;
   logic [CW-1:0] r_col, w_col_d;
`endif

   assign w_any_read = |bus.read;
   assign w_hs       = (r_state == StDrain) && bus.out_ready;
   assign w_idx_inc  = r_idx + 1'b1;
   assign w_word_inc = r_buf[w_idx_inc];
   // First beat must reflect a word captured on this same edge
   assign w_word0    = bus.read[0] ? bus.pe_data[DW-1:0] : r_buf[0];

   always_comb begin
      w_state_d   = r_state;
      w_data_d    = r_data;
      w_idx_d     = r_idx;
      w_last_d    = r_last;
      w_overrun_d = r_overrun;
      w_capture   = 1'b0;
`ifdef SYS_DRAIN_ROW_SUM_EN
      w_is_sum_d  = r_is_sum;
      w_acc_d     = r_acc;
      w_col_d     = r_col;
`endif
      unique case (r_state)
         StIdle: begin
            if (w_any_read) begin
               w_capture = 1'b1;
               w_state_d = StDrain;
            end
         end
         StDrain: begin
            if (w_hs && r_last) begin
               if (w_any_read) w_capture = 1'b1;
               else            w_state_d = StIdle;
            end else begin
               if (w_any_read) w_overrun_d = 1'b1;
               if (w_hs) begin
`ifdef SYS_DRAIN_ROW_SUM_EN
                  if (r_is_sum) begin
                     w_idx_d    = w_idx_inc;
                     w_data_d   = w_word_inc;
                     w_is_sum_d = 1'b0;
                     w_last_d   = 1'b0;
                  end else if (r_col == LastCol) begin
                     // Row complete: hold the index and emit the row sum
                     w_data_d   = r_acc + r_data;
                     w_acc_d    = '0;
                     w_col_d    = '0;
                     w_is_sum_d = 1'b1;
                     w_last_d   = (r_idx == LastIdx);
                  end else begin
                     w_acc_d  = r_acc + r_data;
                     w_col_d  = r_col + 1'b1;
                     w_idx_d  = w_idx_inc;
                     w_data_d = w_word_inc;
                     w_last_d = 1'b0;
                  end
`else
                  w_idx_d  = w_idx_inc;
                  w_data_d = w_word_inc;
                  w_last_d = (w_idx_inc == LastIdx);
`endif
               end
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_capture) begin
         w_idx_d  = '0;
         w_data_d = w_word0;
`ifdef SYS_DRAIN_ROW_SUM_EN
         w_last_d   = 1'b0;
         w_is_sum_d = 1'b0;
         w_acc_d    = '0;
         w_col_d    = '0;
`else
         w_last_d = (LastIdx == '0);
`endif
      end else if (w_state_d == StIdle) begin
         w_idx_d  = '0;
         w_data_d = '0;
         w_last_d = 1'b0;
`ifdef SYS_DRAIN_ROW_SUM_EN
         w_is_sum_d = 1'b0;
         w_acc_d    = '0;
         w_col_d    = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_data    <= '0;
         r_idx     <= '0;
         r_last    <= 1'b0;
         r_overrun <= 1'b0;
`ifdef SYS_DRAIN_ROW_SUM_EN
         r_is_sum  <= 1'b0;
         r_acc     <= '0;
         r_col     <= '0;
`endif
      end else begin
         r_state   <= w_state_d;
         r_data    <= w_data_d;
         r_idx     <= w_idx_d;
         r_last    <= w_last_d;
         r_overrun <= w_overrun_d;
`ifdef SYS_DRAIN_ROW_SUM_EN
         r_is_sum  <= w_is_sum_d;
         r_acc     <= w_acc_d;
         r_col     <= w_col_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NN; i++) r_buf[i] <= '0;
      end else if (w_capture) begin
         for (int unsigned i = 0; i < NN; i++) begin
            if (bus.read[i]) r_buf[i] <= bus.pe_data[i*DW +: DW];
         end
      end
   end

   assign bus.out_data  = r_data;
   assign bus.out_valid = (r_state == StDrain);
   assign bus.busy      = (r_state == StDrain);
   assign bus.out_idx   = r_idx;
   assign bus.out_last  = r_last;
   assign bus.overrun   = r_overrun;
`ifdef SYS_DRAIN_ROW_SUM_EN
   assign bus.out_is_sum = r_is_sum;
`endif
endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: stimulus pushes expected beats, a negedge monitor
// pops and compares every handshake. Honours SYS_DRAIN_ROW_SUM_EN.
module tb_systolic_result_drain;
   localparam int unsigned N  = 5;
   localparam int unsigned DW = 16;
   localparam int unsigned NN = N * N;
   localparam int unsigned IW = $clog2(NN);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
      logic          is_sum;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic tb_is_sum;

   systolic_result_drain_if #(.N(N), .DW(DW)) bus ();

   systolic_result_drain #(.N(N), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

`ifdef SYS_DRAIN_ROW_SUM_EN
   assign tb_is_sum = bus.out_is_sum;
`else
   assign tb_is_sum = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic set_pe(input int off, input int mul);
      for (int i = 0; i < int'(NN); i++) bus.pe_data[i*DW +: DW] = DW'(off + mul * i);
   endtask

   task automatic push_frame(input int off, input int mul);
      int acc;
      for (int r = 0; r < int'(N); r++) begin
         acc = 0;
         for (int c = 0; c < int'(N); c++) begin
            exp_t e;
            int   i;
            i        = r * int'(N) + c;
            e.data   = DW'(off + mul * i);
            e.idx    = IW'(i);
            e.is_sum = 1'b0;
`ifdef SYS_DRAIN_ROW_SUM_EN
            e.last   = 1'b0;
`else
            e.last   = (i == int'(NN) - 1);
`endif
            acc += off + mul * i;
            exp_q.push_back(e);
         end
`ifdef SYS_DRAIN_ROW_SUM_EN
         begin
            exp_t s;
            s.data   = DW'(acc);
            s.idx    = IW'(r * int'(N) + int'(N) - 1);
            s.last   = (r == int'(N) - 1);
            s.is_sum = 1'b1;
            exp_q.push_back(s);
         end
`endif
      end
   endtask

   // kind 0: data beat at index val visible; 1: out_last visible; 2: idle
   task automatic wait_for(input int kind, input int val, input string name);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge clk);
         #1;
         case (kind)
            0:       hit = bus.out_valid && (bus.out_idx == IW'(val)) && !tb_is_sum;
            1:       hit = bus.out_valid && bus.out_last;
            default: hit = !bus.busy;
         endcase
      end
      if (!hit) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: timed out, got no event, required event within 200 cycles", name);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_data"}, bus.out_data, 0);
      check({tag, "_idx"}, bus.out_idx, 0);
      check({tag, "_last"}, bus.out_last, 0);
      check({tag, "_overrun"}, bus.overrun, 0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         check("busy_eq_valid", bus.busy, bus.out_valid);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat_idx", bus.out_idx, -1);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", bus.out_data, e.data);
               check("beat_idx", bus.out_idx, e.idx);
               check("beat_last", bus.out_last, e.last);
               check("beat_is_sum", tb_is_sum, e.is_sum);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required $finish earlier", $time);
      $fatal(1);
   end

   initial begin
      bus.read      = '0;
      bus.pe_data   = '0;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Frame A: 3*i, backpressure at index 7
      set_pe(0, 3);
      push_frame(0, 3);
      bus.read = '1;
      check("valid_before_edge", bus.out_valid, 0);
      @(posedge clk);
      #1;
      bus.read = '0;
      check("first_valid", bus.out_valid, 1);
      check("first_idx", bus.out_idx, 0);
      check("first_data", bus.out_data, 0);

      wait_for(0, 7, "wait_idx7");
      bus.out_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("hold_data", bus.out_data, 21);
         check("hold_idx", bus.out_idx, 7);
         check("hold_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;

      // Frame B captured on frame A's last handshake
      wait_for(1, 0, "wait_last_a");
      set_pe(100, 2);
      push_frame(100, 2);
      bus.read = '1;
      @(posedge clk);
      #1;
      bus.read = '0;
      check("b2b_busy", bus.busy, 1);
      check("b2b_idx", bus.out_idx, 0);
      check("b2b_data", bus.out_data, 100);
      check("b2b_overrun", bus.overrun, 0);

      // Overrun mid-frame B: stream must keep frame B data
      wait_for(0, 10, "wait_idx10");
      set_pe(1000, 1);
      bus.read = '1;
      @(posedge clk);
      #1;
      bus.read = '0;
      check("overrun_set", bus.overrun, 1);
      check("overrun_idx_advances", bus.out_idx, 11);
      wait_for(2, 0, "wait_idle_b");
      check("overrun_sticky_idle", bus.overrun, 1);
      check("queue_empty_b", exp_q.size(), 0);

      // Frame C streams the data presented during the ignored strobe
      push_frame(1000, 1);
      bus.read = '1;
      @(posedge clk);
      #1;
      bus.read = '0;
      wait_for(1, 0, "wait_last_c");
      @(posedge clk);
      #1;
      check("end_busy", bus.busy, 0);
      check("end_valid", bus.out_valid, 0);
      check("end_overrun", bus.overrun, 1);
      check("queue_empty_c", exp_q.size(), 0);

      // Reset mid-frame abandons the stream
      set_pe(5, 1);
      push_frame(5, 1);
      bus.read = '1;
      @(posedge clk);
      #1;
      bus.read = '0;
      wait_for(0, 4, "wait_idx4");
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_busy", bus.busy, 0);
      check("post_reset_overrun", bus.overrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
